ysyx_24100029_wbu: RTL and testbench
====================================

// Module: ysyx_24100029_wbu
// PURPOSE
//  Write-back stage: consumes LSU results via valid/ready handshake, holds one
//  commit slot, writes the 32x32 GPR file and the machine CSRs, counts retired
//  instructions. Sits directly downstream of LSU; GPR read ports and CSR values
//  are exported to IDU/EXU/IFU.
// PARAMETERS
//  NR_REG   32   GPR count (x0 hardwired to 0)
//  XLEN     32   data width
// PORTS
//  clock         in   1    system clock
//  reset         in   1    asynchronous, active-low (asserted when 0)
//  valid_last    in   1    LSU has a result
//  ready_last    out  1    WBU can accept
//  pc            in   32   instruction PC
//  inst          in   32   instruction word
//  R_wen         in   1    GPR write request
//  rd            in   5    GPR destination
//  mem_ren       in   1    result is a load
//  LSU_Rdata     in   32   load data
//  Ex_result     in   32   ALU/CSR-read result
//  csr_wen       in   4    CSR write enables (encoding below)
//  csrs          in   32   CSR write value
//  jump_flag     in   1    instruction redirected control flow
//  rs1_addr      in   5    GPR read address 1
//  rs2_addr      in   5    GPR read address 2
//  rs1_value     out  32   GPR read data 1 (with bypass)
//  rs2_value     out  32   GPR read data 2 (with bypass)
//  mstatus/mtvec/mepc/mcause  out 32 each  current CSR values
//  minstret      out  64   retired-instruction count
//  wb_busy_rd    out  5    rd of occupied commit slot with R_wen, else 0
// BEHAVIOUR
//  - Async reset (reset==0): ready_last=0, slot empty, GPRs=0, mstatus=0x1800,
//    mtvec=mepc=mcause=0, minstret=0. ready_last rises on first edge after release.
//  - Accept on edge where valid_last & ready_last: capture all inputs into slot.
//  - Commit cycle = cycle after accept (slot valid). At the edge ending it:
//    GPR[rd] <= mem_ren ? LSU_Rdata : Ex_result if R_wen & rd!=0; CSR update;
//    minstret += 1 (64-bit wrap 0xFFFF_FFFF_FFFF_FFFF -> 0); slot empties
//    unless a new accept happens on the same edge (back-to-back, 1 instr/cycle).
//  - ready_last = 1 whenever out of reset; slot never stalls upstream.
//  - CSR encoding: 4'b1100 = ecall: mepc<=pc, mcause<=csrs. Otherwise each set
//    bit writes csrs: [0] mstatus, [1] mtvec, [2] mepc, [3] mcause.
//  - GPR write and CSR write from one commit occur on the same edge.
//  - Reads combinational; rsN_addr==0 -> 0; if rsN_addr==slot rd, slot valid,
//    R_wen, rd!=0 -> committing value returned (write-through bypass).
//  - wb_busy_rd valid combinationally during commit cycle; 0 when slot empty.
//  - CSR outputs are registered values, no bypass (upstream interlocks).
//  - reset asserted mid-commit: commit discarded, all state to reset values.
// CONFIGURATION
//  WBU_COMMIT_TRACE_EN defined: adds outputs commit_valid(1), commit_pc(32),
//   commit_inst(32), commit_jump(1), driven from slot during commit cycle
//   (commit_valid=0 in reset/empty) for difftest.
//  Not defined: ports absent, no trace logic.
// TESTING
//  - Reset release, idle -> ready_last=1 next edge, all GPR reads 0, mstatus=0x1800.
//  - Accept R_wen=1,rd=5,mem_ren=0,Ex_result=0x1234 -> commit cycle rs1_addr=5
//    reads 0x1234 (bypass); after edge GPR[5]=0x1234, minstret=1.
//  - Load: mem_ren=1,LSU_Rdata=0xDEADBEEF,rd=0 -> x0 stays 0, minstret increments.
//  - ecall: csr_wen=4'b1100,pc=0x80000010,csrs=11 -> mepc=0x80000010, mcause=11.
//  - 4 back-to-back valid_last cycles -> 4 commits in 4 cycles, minstret=4.
//  - Drop reset during commit cycle -> GPR not written, minstret=0, ready_last=0.

Source files
------------

// File: rtl/ysyx_24100029_wbu_if.sv
// LSU -> WBU result handshake and payload bundle.
interface ysyx_24100029_wbu_if #(
    parameter int XLEN = 32
);
    logic            valid_last;
    logic            ready_last;
    logic [31:0]     pc;
    logic [31:0]     inst;
    logic            R_wen;
    logic [4:0]      rd;
    logic            mem_ren;
    logic [XLEN-1:0] LSU_Rdata;
    logic [XLEN-1:0] Ex_result;
    logic [3:0]      csr_wen;
    logic [XLEN-1:0] csrs;
    logic            jump_flag;

    modport master (
        output valid_last, pc, inst, R_wen, rd, mem_ren, LSU_Rdata, Ex_result,
               csr_wen, csrs, jump_flag,
        input  ready_last
    );

    modport slave (
        input  valid_last, pc, inst, R_wen, rd, mem_ren, LSU_Rdata, Ex_result,
               csr_wen, csrs, jump_flag,
        output ready_last
    );
endinterface

// File: rtl/ysyx_24100029_wbu.sv
// Write-back stage: one commit slot feeding the GPR file, machine CSRs and minstret.
// Define WBU_COMMIT_TRACE_EN to expose the committing instruction for difftest.
module ysyx_24100029_wbu #(
    parameter int NR_REG = 32,
    parameter int XLEN   = 32
) (
    input  logic                clock,
    input  logic                reset,
    ysyx_24100029_wbu_if.slave  lsu,
    input  logic [4:0]          rs1_addr,
    input  logic [4:0]          rs2_addr,
    output logic [XLEN-1:0]     rs1_value,
    output logic [XLEN-1:0]     rs2_value,
    output logic [XLEN-1:0]     mstatus,
    output logic [XLEN-1:0]     mtvec,
    output logic [XLEN-1:0]     mepc,
    output logic [XLEN-1:0]     mcause,
    output logic [63:0]         minstret,
    output logic [4:0]          wb_busy_rd
`ifdef WBU_COMMIT_TRACE_EN
    ,
    output logic                commit_valid,
    output logic [31:0]         commit_pc,
    output logic [31:0]         commit_inst,
    output logic                commit_jump
`endif
);
    typedef struct packed {
        logic [31:0]     pc;
        logic [31:0]     inst;
        logic            r_wen;
        logic [4:0]      rd;
        logic            mem_ren;
        logic [XLEN-1:0] lsu_rdata;
        logic [XLEN-1:0] ex_result;
        logic [3:0]      csr_wen;
        logic [XLEN-1:0] csrs;
        logic            jump_flag;
    } slot_t;

    localparam logic [3:0]      CSR_ECALL     = 4'b1100;
    localparam logic [XLEN-1:0] MSTATUS_RESET = XLEN'(32'h0000_1800);

    logic                         ready_q;
    logic                         slot_vld;
    slot_t                        slot;
    logic [NR_REG-1:0][XLEN-1:0]  gpr;
    logic                         accept;
    logic                         gpr_we;
    logic [XLEN-1:0]              wdata;

    assign accept         = lsu.valid_last & ready_q;
    assign lsu.ready_last = ready_q;
    assign wdata          = slot.mem_ren ? slot.lsu_rdata : slot.ex_result;
    assign gpr_we         = slot_vld & slot.r_wen & (slot.rd != 5'd0);

    // The slot drains every cycle, so upstream is never back-pressured.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            ready_q  <= 1'b0;
            slot_vld <= 1'b0;
            slot     <= '0;
        end else begin
            ready_q  <= 1'b1;
            slot_vld <= accept;
            if (accept) begin
                slot.pc        <= lsu.pc;
                slot.inst      <= lsu.inst;
                slot.r_wen     <= lsu.R_wen;
                slot.rd        <= lsu.rd;
                slot.mem_ren   <= lsu.mem_ren;
                slot.lsu_rdata <= lsu.LSU_Rdata;
                slot.ex_result <= lsu.Ex_result;
                slot.csr_wen   <= lsu.csr_wen;
                slot.csrs      <= lsu.csrs;
                slot.jump_flag <= lsu.jump_flag;
            end
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            gpr <= '0;
        end else if (gpr_we) begin
            gpr[slot.rd] <= wdata;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            mstatus  <= MSTATUS_RESET;
            mtvec    <= '0;
            mepc     <= '0;
            mcause   <= '0;
            minstret <= '0;
        end else if (slot_vld) begin
            minstret <= minstret + 64'd1;
            // ecall reuses the mepc|mcause enable pattern but takes mepc from pc
            if (slot.csr_wen == CSR_ECALL) begin
                mepc   <= XLEN'(slot.pc);
                mcause <= slot.csrs;
            end else begin
                if (slot.csr_wen[0]) mstatus <= slot.csrs;
                if (slot.csr_wen[1]) mtvec   <= slot.csrs;
                if (slot.csr_wen[2]) mepc    <= slot.csrs;
                if (slot.csr_wen[3]) mcause  <= slot.csrs;
            end
        end
    end

    // Write-through bypass so readers see the value committing this cycle.
    assign rs1_value = (rs1_addr == 5'd0)                  ? '0    :
                       (gpr_we && rs1_addr == slot.rd)     ? wdata :
                                                             gpr[rs1_addr];
    assign rs2_value = (rs2_addr == 5'd0)                  ? '0    :
                       (gpr_we && rs2_addr == slot.rd)     ? wdata :
                                                             gpr[rs2_addr];

    assign wb_busy_rd = (slot_vld && slot.r_wen) ? slot.rd : 5'd0;

`ifdef WBU_COMMIT_TRACE_EN
    assign commit_valid = slot_vld;
    assign commit_pc    = slot.pc;
    assign commit_inst  = slot.inst;
    assign commit_jump  = slot.jump_flag;
`else
    logic unused_trace;
    assign unused_trace = ^{slot.inst, slot.jump_flag};
`endif
endmodule

// File: tb/tb_ysyx_24100029_wbu.sv
// Scoreboard bench for the write-back stage: stimulus pushes expectations, a negedge monitor checks them.
module tb_ysyx_24100029_wbu;
    logic        clock = 1'b0;
    logic        reset;
    logic [4:0]  rs1_addr, rs2_addr, main_rs1, main_rs2, mon_rs1, mon_rs2;
    logic        mon_en;
    logic [31:0] rs1_value, rs2_value, mstatus, mtvec, mepc, mcause;
    logic [63:0] minstret, prev_mi;
    logic [4:0]  wb_busy_rd;
    int          errors = 0;
    int          checks = 0;

    always #5 clock = ~clock;

    ysyx_24100029_wbu_if lsu_if ();

    assign rs1_addr = mon_en ? mon_rs1 : main_rs1;
    assign rs2_addr = mon_en ? mon_rs2 : main_rs2;

    ysyx_24100029_wbu dut (
        .clock      (clock),
        .reset      (reset),
        .lsu        (lsu_if),
        .rs1_addr   (rs1_addr),
        .rs2_addr   (rs2_addr),
        .rs1_value  (rs1_value),
        .rs2_value  (rs2_value),
        .mstatus    (mstatus),
        .mtvec      (mtvec),
        .mepc       (mepc),
        .mcause     (mcause),
        .minstret   (minstret),
        .wb_busy_rd (wb_busy_rd)
    );

    typedef struct {
        logic [4:0]  rd;
        logic [31:0] val;
    } byp_t;

    typedef struct {
        logic [63:0] mi;
        logic        chk_gpr;
        logic [4:0]  rd;
        logic [31:0] val;
        logic [31:0] ms, tv, ep, mc;
    } cmt_t;

    byp_t bq[$];
    cmt_t cq[$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic exp_byp(input logic [4:0] rd, input logic [31:0] val);
        byp_t b;
        b.rd = rd; b.val = val;
        bq.push_back(b);
    endtask

    task automatic exp_cmt(input logic [63:0] mi, input logic chk_gpr, input logic [4:0] rd,
                           input logic [31:0] val, input logic [31:0] ms, input logic [31:0] tv,
                           input logic [31:0] ep, input logic [31:0] mc);
        cmt_t c;
        c.mi = mi; c.chk_gpr = chk_gpr; c.rd = rd; c.val = val;
        c.ms = ms; c.tv = tv; c.ep = ep; c.mc = mc;
        cq.push_back(c);
    endtask

    // Drive one result for a single clock; returns just after the accepting edge.
    task automatic issue(input logic rw, input logic [4:0] rd, input logic mr,
                         input logic [31:0] ldata, input logic [31:0] ex,
                         input logic [3:0] cw, input logic [31:0] cs, input logic [31:0] pc);
        lsu_if.valid_last = 1'b1;
        lsu_if.R_wen      = rw;
        lsu_if.rd         = rd;
        lsu_if.mem_ren    = mr;
        lsu_if.LSU_Rdata  = ldata;
        lsu_if.Ex_result  = ex;
        lsu_if.csr_wen    = cw;
        lsu_if.csrs       = cs;
        lsu_if.pc         = pc;
        lsu_if.inst       = 32'h0000_0013;
        lsu_if.jump_flag  = 1'b0;
        @(posedge clock);
        #1;
        lsu_if.valid_last = 1'b0;
        lsu_if.R_wen      = 1'b0;
        lsu_if.csr_wen    = 4'b0;
    endtask

    // Monitor: a nonzero wb_busy_rd marks a GPR-writing commit cycle; a +1 step of minstret marks a retired commit.
    always begin
        byp_t b;
        cmt_t c;
        logic do_b, do_c;
        @(negedge clock);
        if (mon_en) begin
            do_b = (wb_busy_rd != 5'd0);
            do_c = (minstret == prev_mi + 64'd1);
            if (!do_c && minstret != prev_mi) chk("minstret_step", minstret, prev_mi + 64'd1);
            if (do_b) begin
                if (bq.size() == 0) begin
                    chk("unexpected_bypass", 64'(wb_busy_rd), 64'd0);
                    do_b = 1'b0;
                end else begin
                    b = bq.pop_front();
                    mon_rs1 = b.rd;
                end
            end
            if (do_c) begin
                if (cq.size() == 0) begin
                    chk("unexpected_commit", minstret, prev_mi);
                    do_c = 1'b0;
                end else begin
                    c = cq.pop_front();
                    mon_rs2 = c.rd;
                end
            end
            #1;
            if (do_b) begin
                chk("busy_rd", 64'(wb_busy_rd), 64'(b.rd));
                chk("bypass_rs1", 64'(rs1_value), 64'(b.val));
            end
            if (do_c) begin
                chk("minstret", minstret, c.mi);
                chk("mstatus", 64'(mstatus), 64'(c.ms));
                chk("mtvec", 64'(mtvec), 64'(c.tv));
                chk("mepc", 64'(mepc), 64'(c.ep));
                chk("mcause", 64'(mcause), 64'(c.mc));
                if (c.chk_gpr) chk("gpr_rs2", 64'(rs2_value), 64'(c.val));
            end
        end
        prev_mi = minstret;
    end

    initial begin
        reset    = 1'b0;
        mon_en   = 1'b0;
        main_rs1 = 5'd0; main_rs2 = 5'd0;
        mon_rs1  = 5'd0; mon_rs2  = 5'd0;
        prev_mi  = 64'd0;
        lsu_if.valid_last = 1'b0; lsu_if.R_wen = 1'b0; lsu_if.rd = 5'd0;
        lsu_if.mem_ren = 1'b0; lsu_if.LSU_Rdata = '0; lsu_if.Ex_result = '0;
        lsu_if.csr_wen = 4'b0; lsu_if.csrs = '0; lsu_if.pc = '0;
        lsu_if.inst = '0; lsu_if.jump_flag = 1'b0;

        repeat (3) @(posedge clock);
        #1;
        chk("rst_ready", 64'(lsu_if.ready_last), 64'd0);
        chk("rst_mstatus", 64'(mstatus), 64'h1800);
        chk("rst_mtvec", 64'(mtvec), 64'd0);
        chk("rst_minstret", minstret, 64'd0);
        chk("rst_busy_rd", 64'(wb_busy_rd), 64'd0);

        @(negedge clock);
        reset = 1'b1;
        #1;
        chk("ready_before_edge", 64'(lsu_if.ready_last), 64'd0);
        @(posedge clock);
        #1;
        chk("ready_after_edge", 64'(lsu_if.ready_last), 64'd1);
        main_rs1 = 5'd5; main_rs2 = 5'd31;
        #1;
        chk("idle_rs1_x5", 64'(rs1_value), 64'd0);
        chk("idle_rs2_x31", 64'(rs2_value), 64'd0);
        mon_en = 1'b1;

        // ALU write to x5
        exp_byp(5'd5, 32'h1234);
        exp_cmt(64'd1, 1'b1, 5'd5, 32'h1234, 32'h1800, 0, 0, 0);
        issue(1'b1, 5'd5, 1'b0, 32'hFFFF_0000, 32'h1234, 4'b0, 32'h0, 32'h8000_0000);
        // load targeting x0 is dropped
        exp_cmt(64'd2, 1'b1, 5'd0, 32'h0, 32'h1800, 0, 0, 0);
        issue(1'b1, 5'd0, 1'b1, 32'hDEAD_BEEF, 32'h5555, 4'b0, 32'h0, 32'h8000_0004);
        repeat (2) @(posedge clock);
        #1;
        // ecall
        exp_cmt(64'd3, 1'b0, 5'd0, 32'h0, 32'h1800, 0, 32'h8000_0010, 32'd11);
        issue(1'b0, 5'd0, 1'b0, 32'h0, 32'h0, 4'b1100, 32'd11, 32'h8000_0010);
        // GPR and CSR writes in the same commit
        exp_byp(5'd6, 32'h66);
        exp_cmt(64'd4, 1'b1, 5'd6, 32'h66, 32'h1888, 32'h1888, 32'h8000_0010, 32'd11);
        issue(1'b1, 5'd6, 1'b0, 32'h0, 32'h66, 4'b0011, 32'h1888, 32'h8000_0014);
        repeat (2) @(posedge clock);
        #1;

        // four back-to-back results
        exp_byp(5'd10, 32'hA0A0_0001);
        exp_cmt(64'd5, 1'b1, 5'd10, 32'hA0A0_0001, 32'h1888, 32'h1888, 32'h8000_0010, 32'd11);
        exp_byp(5'd11, 32'hB1B1_0002);
        exp_cmt(64'd6, 1'b1, 5'd11, 32'hB1B1_0002, 32'h1888, 32'h1888, 32'h8000_0010, 32'd11);
        exp_byp(5'd12, 32'h0000_00C2);
        exp_cmt(64'd7, 1'b1, 5'd12, 32'h0000_00C2, 32'h1888, 32'h1888, 32'h8000_0010, 32'd11);
        exp_byp(5'd13, 32'h0000_00D3);
        exp_cmt(64'd8, 1'b1, 5'd13, 32'h0000_00D3, 32'h1888, 32'h1888, 32'h8000_0010, 32'd11);
        issue(1'b1, 5'd10, 1'b0, 32'h7777, 32'hA0A0_0001, 4'b0, 0, 32'h8000_0020);
        issue(1'b1, 5'd11, 1'b1, 32'hB1B1_0002, 32'h1111, 4'b0, 0, 32'h8000_0024);
        issue(1'b1, 5'd12, 1'b0, 32'h8888, 32'h0000_00C2, 4'b0, 0, 32'h8000_0028);
        issue(1'b1, 5'd13, 1'b1, 32'h0000_00D3, 32'h9999, 4'b0, 0, 32'h8000_002C);
        repeat (2) @(posedge clock);
        #1;

        // single-bit mepc then mcause writes
        exp_cmt(64'd9, 1'b0, 5'd0, 0, 32'h1888, 32'h1888, 32'h8000_0200, 32'd11);
        issue(1'b0, 5'd0, 1'b0, 0, 0, 4'b0100, 32'h8000_0200, 32'h8000_0300);
        exp_cmt(64'd10, 1'b0, 5'd0, 0, 32'h1888, 32'h1888, 32'h8000_0200, 32'd7);
        issue(1'b0, 5'd0, 1'b0, 0, 0, 4'b1000, 32'd7, 32'h8000_0304);
        repeat (2) @(posedge clock);
        #1;

        // reset lands in the middle of a commit cycle
        exp_byp(5'd7, 32'h77);
        issue(1'b1, 5'd7, 1'b0, 0, 32'h77, 4'b0001, 32'hABCD, 32'h8000_0400);
        @(negedge clock);
        #2;
        mon_en = 1'b0;
        reset  = 1'b0;
        main_rs1 = 5'd7; main_rs2 = 5'd5;
        #1;
        chk("midrst_minstret", minstret, 64'd0);
        chk("midrst_ready", 64'(lsu_if.ready_last), 64'd0);
        chk("midrst_x7", 64'(rs1_value), 64'd0);
        chk("midrst_x5", 64'(rs2_value), 64'd0);
        chk("midrst_mstatus", 64'(mstatus), 64'h1800);
        chk("midrst_mepc", 64'(mepc), 64'd0);
        chk("midrst_busy_rd", 64'(wb_busy_rd), 64'd0);
        @(posedge clock);
        #1;
        chk("held_minstret", minstret, 64'd0);
        chk("held_ready", 64'(lsu_if.ready_last), 64'd0);
        chk("held_x7", 64'(rs1_value), 64'd0);

        chk("byp_queue_empty", 64'(bq.size()), 64'd0);
        chk("cmt_queue_empty", 64'(cq.size()), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
